// File: rtl/memory_scheduler_if.sv
// Bus bundle for memory_scheduler: packet sources, read request, SRAM command
// interface and address-counter handshakes.
// Optional DROP_COUNT signal present when MEMSCHED_DROP_COUNT_EN is defined.
interface memory_scheduler_if #(
  parameter int NUM_CH     = 2,
  parameter int PKT_WIDTH  = 80,
  parameter int WORD_WIDTH = 16,
  parameter int ADDR_WIDTH = 18
);
  logic [NUM_CH*PKT_WIDTH-1:0] CH_DATA;
  logic [NUM_CH-1:0]           CH_VALID;
  logic                        READ_CMD;
  logic                        SRAM_STATUS;
  logic [ADDR_WIDTH-1:0]       WRITE_ADDRESS;
  logic                        WRITE_CHIP_SELECT;
  logic [ADDR_WIDTH-1:0]       READ_ADDRESS;
  logic                        READ_CHIP_SELECT;
  logic [1:0]                  CMD_OUT;
  logic [ADDR_WIDTH-1:0]       ADDRESS_OUT;
  logic                        CHIP_SELECT;
  logic [WORD_WIDTH-1:0]       DATA_OUT;
  logic                        NEXT_WRITE;
  logic                        NEXT_READ;
  logic                        DROP;
  logic                        TIMEOUT_ERR;
`ifdef MEMSCHED_DROP_COUNT_EN
  logic [7:0]                  DROP_COUNT;
`endif

  // Environment side: sources, counters and SRAM status drive the scheduler.
  modport master (
    output CH_DATA, CH_VALID, READ_CMD, SRAM_STATUS,
    output WRITE_ADDRESS, WRITE_CHIP_SELECT, READ_ADDRESS, READ_CHIP_SELECT,
    input  CMD_OUT, ADDRESS_OUT, CHIP_SELECT, DATA_OUT,
    input  NEXT_WRITE, NEXT_READ, DROP, TIMEOUT_ERR
`ifdef MEMSCHED_DROP_COUNT_EN
    , input DROP_COUNT
`endif
  );

  // Scheduler side.
  modport slave (
    input  CH_DATA, CH_VALID, READ_CMD, SRAM_STATUS,
    input  WRITE_ADDRESS, WRITE_CHIP_SELECT, READ_ADDRESS, READ_CHIP_SELECT,
    output CMD_OUT, ADDRESS_OUT, CHIP_SELECT, DATA_OUT,
    output NEXT_WRITE, NEXT_READ, DROP, TIMEOUT_ERR
`ifdef MEMSCHED_DROP_COUNT_EN
    , output DROP_COUNT
`endif
  );
endinterface

// File: rtl/memory_scheduler.sv
// memory_scheduler: queues packet writes from NUM_CH sources and read requests
// in arrival order, then sequences them onto the SRAM interface one word-sized
// command at a time (least-significant word first).
// Optional feature: MEMSCHED_DROP_COUNT_EN adds an 8-bit saturating DROP_COUNT.
module memory_scheduler #(
  parameter int NUM_CH       = 2,
  parameter int PKT_WIDTH    = 80,
  parameter int WORD_WIDTH   = 16,
  parameter int ADDR_WIDTH   = 18,
  parameter int QUEUE_DEPTH  = 4,
  parameter int BUSY_TIMEOUT = 15
) (
  input logic          CLK_48MHZ,
  input logic          RESET,
  memory_scheduler_if.slave bus
);

  localparam int WORDS = PKT_WIDTH / WORD_WIDTH;
  localparam int WC_W  = $clog2(WORDS) + 1;
  localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int PTR_W = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
  localparam int CNT_W = $clog2(QUEUE_DEPTH + 1);
  localparam int TMR_W = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;

  // Queue pointer advance, wrapping modulo QUEUE_DEPTH (depth need not be a power of two).
  function automatic logic [PTR_W-1:0] ptr_add(input logic [PTR_W-1:0] p, input logic [CNT_W-1:0] n);
    int unsigned s;
    s = (int'(p) + int'(n)) % QUEUE_DEPTH;
    return PTR_W'(s);
  endfunction

  // Capture state
  logic [PKT_WIDTH-1:0] pkt_buf_r [NUM_CH];
  logic [NUM_CH-1:0]    pend_r;
  logic                 rd_pend_r;
  logic                 read_cmd_q_r;
  logic                 drop_r;

  // Operation queue: each entry is a read flag plus a source channel
  logic                 q_rd_r [QUEUE_DEPTH];
  logic [CH_W-1:0]      q_ch_r [QUEUE_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_r;
  logic [PTR_W-1:0]     rd_ptr_r;
  logic [CNT_W-1:0]     q_cnt_r;

  // Sequencer state
  state_t               state_r;
  logic                 cur_rd_r;
  logic [CH_W-1:0]      cur_ch_r;
  logic [PKT_WIDTH-1:0] shift_r;
  logic [WC_W-1:0]      word_cnt_r;
  logic [TMR_W-1:0]     timer_r;
  logic [1:0]           cmd_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic                 cs_r;
  logic [WORD_WIDTH-1:0] data_r;
  logic                 next_wr_r;
  logic                 next_rd_r;
  logic                 timeout_r;

  // Combinational request decode
  logic [NUM_CH-1:0]    push_wr_s;
  logic [PTR_W-1:0]     slot_s [NUM_CH];
  logic                 push_rd_s;
  logic [PTR_W-1:0]     slot_rd_s;
  logic [CNT_W-1:0]     push_cnt_s;
  logic                 drop_s;
  logic                 read_rise_s;

  // Combinational completion decode
  logic                 head_rd_s;
  logic [CH_W-1:0]      head_ch_s;
  logic                 addr_match_s;
  logic                 catchup_s;
  logic                 done_s;
  logic [WC_W-1:0]      word_next_s;
  logic                 last_word_s;
  logic                 pop_s;
  logic                 clr_rd_s;
  logic                 clr_wr_s;

  // Accept or drop new requests; same-cycle pushes land in order ch0..chN-1, then read.
  always_comb begin
    push_cnt_s  = '0;
    drop_s      = 1'b0;
    push_wr_s   = '0;
    read_rise_s = bus.READ_CMD & ~read_cmd_q_r;
    for (int i = 0; i < NUM_CH; i++) begin
      slot_s[i] = wr_ptr_r;
      if (bus.CH_VALID[i]) begin
        if (!pend_r[i]) begin
          push_wr_s[i] = 1'b1;
          slot_s[i]    = ptr_add(wr_ptr_r, push_cnt_s);
          push_cnt_s   = push_cnt_s + CNT_W'(1);
        end else begin
          drop_s = 1'b1;
        end
      end else begin
        push_wr_s[i] = 1'b0;
      end
    end
    push_rd_s = 1'b0;
    slot_rd_s = ptr_add(wr_ptr_r, push_cnt_s);
    if (read_rise_s) begin
      if (!rd_pend_r) begin
        push_rd_s  = 1'b1;
        push_cnt_s = push_cnt_s + CNT_W'(1);
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      push_rd_s = 1'b0;
    end
  end

  // Decide when the head operation retires and which pending flag it releases.
  always_comb begin
    head_rd_s    = q_rd_r[rd_ptr_r];
    head_ch_s    = q_ch_r[rd_ptr_r];
    addr_match_s = (bus.READ_ADDRESS == bus.WRITE_ADDRESS) &&
                   (bus.READ_CHIP_SELECT == bus.WRITE_CHIP_SELECT);
    catchup_s    = (state_r == IDLE) && (q_cnt_r != '0) && head_rd_s && addr_match_s;
    done_s       = (state_r == WAIT_DONE) && !bus.SRAM_STATUS;
    word_next_s  = word_cnt_r + WC_W'(1);
    if (cur_rd_r) begin
      last_word_s = 1'b1;
    end else begin
      last_word_s = (word_next_s == WC_W'(WORDS));
    end
    pop_s    = catchup_s | (done_s & last_word_s);
    clr_rd_s = catchup_s | (done_s & cur_rd_r);
    clr_wr_s = done_s & ~cur_rd_r & last_word_s;
  end

  // Operation queue storage and pointers.
  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      for (int k = 0; k < QUEUE_DEPTH; k++) begin
        q_rd_r[k] <= 1'b0;
        q_ch_r[k] <= '0;
      end
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      q_cnt_r  <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push_wr_s[i]) begin
          q_rd_r[slot_s[i]] <= 1'b0;
          q_ch_r[slot_s[i]] <= CH_W'(i);
        end
      end
      if (push_rd_s) begin
        q_rd_r[slot_rd_s] <= 1'b1;
        q_ch_r[slot_rd_s] <= '0;
      end
      wr_ptr_r <= ptr_add(wr_ptr_r, push_cnt_s);
      rd_ptr_r <= pop_s ? ptr_add(rd_ptr_r, CNT_W'(1)) : rd_ptr_r;
      q_cnt_r  <= q_cnt_r + push_cnt_s - CNT_W'(pop_s);
    end
  end

  // Packet buffers, pending flags, read-edge detect and the DROP pulse.
  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < NUM_CH; i++) begin
        pkt_buf_r[i] <= '0;
      end
      pend_r       <= '0;
      rd_pend_r    <= 1'b0;
      read_cmd_q_r <= 1'b0;
      drop_r       <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (push_wr_s[i]) begin
          pend_r[i]    <= 1'b1;
          pkt_buf_r[i] <= bus.CH_DATA[i*PKT_WIDTH +: PKT_WIDTH];
        end else if (clr_wr_s && (cur_ch_r == CH_W'(i))) begin
          pend_r[i] <= 1'b0;
        end
      end
      if (push_rd_s) begin
        rd_pend_r <= 1'b1;
      end else if (clr_rd_s) begin
        rd_pend_r <= 1'b0;
      end
      read_cmd_q_r <= bus.READ_CMD;
      drop_r       <= drop_s;
    end
  end

  // Command sequencer: issue each word, wait for busy then idle, retry on busy timeout.
  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      state_r    <= IDLE;
      cur_rd_r   <= 1'b0;
      cur_ch_r   <= '0;
      shift_r    <= '0;
      word_cnt_r <= '0;
      timer_r    <= '0;
      cmd_r      <= 2'b00;
      addr_r     <= '0;
      cs_r       <= 1'b0;
      data_r     <= '0;
      next_wr_r  <= 1'b0;
      next_rd_r  <= 1'b0;
      timeout_r  <= 1'b0;
    end else begin
      next_wr_r <= 1'b0;
      next_rd_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (q_cnt_r != '0) begin
            cur_rd_r <= head_rd_s;
            cur_ch_r <= head_ch_s;
            if (head_rd_s) begin
              // Reads that have caught up with writes retire silently.
              state_r <= addr_match_s ? IDLE : ISSUE;
            end else begin
              shift_r    <= pkt_buf_r[head_ch_s];
              word_cnt_r <= '0;
              state_r    <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (!bus.SRAM_STATUS) begin
            timer_r <= '0;
            state_r <= WAIT_BUSY;
            if (cur_rd_r) begin
              cmd_r  <= 2'b01;
              addr_r <= bus.READ_ADDRESS;
              cs_r   <= bus.READ_CHIP_SELECT;
            end else begin
              cmd_r  <= 2'b10;
              addr_r <= bus.WRITE_ADDRESS;
              cs_r   <= bus.WRITE_CHIP_SELECT;
              data_r <= shift_r[WORD_WIDTH-1:0];
            end
          end
        end
        WAIT_BUSY: begin
          if (bus.SRAM_STATUS) begin
            cmd_r   <= 2'b00;
            state_r <= WAIT_DONE;
          end else if (timer_r == TMR_W'(BUSY_TIMEOUT - 1)) begin
            cmd_r     <= 2'b00;
            timeout_r <= 1'b1;
            state_r   <= ISSUE;
          end else begin
            timer_r <= timer_r + TMR_W'(1);
          end
        end
        WAIT_DONE: begin
          if (!bus.SRAM_STATUS) begin
            if (cur_rd_r) begin
              next_rd_r <= 1'b1;
              state_r   <= IDLE;
            end else begin
              next_wr_r  <= 1'b1;
              shift_r    <= shift_r >> WORD_WIDTH;
              word_cnt_r <= word_next_s;
              state_r    <= last_word_s ? IDLE : ISSUE;
            end
          end
        end
        default: begin
          state_r <= IDLE;
          cmd_r   <= 2'b00;
        end
      endcase
    end
  end

`ifdef MEMSCHED_DROP_COUNT_EN
  logic [7:0] drop_cnt_r;

  // Saturating count of discarded requests.
  always_ff @(posedge CLK_48MHZ or posedge RESET) begin
    if (RESET) begin
      drop_cnt_r <= 8'd0;
    end else if (drop_s && (drop_cnt_r != 8'd255)) begin
      drop_cnt_r <= drop_cnt_r + 8'd1;
    end
  end

  assign bus.DROP_COUNT = drop_cnt_r;
`endif

  assign bus.CMD_OUT     = cmd_r;
  assign bus.ADDRESS_OUT = addr_r;
  assign bus.CHIP_SELECT = cs_r;
  assign bus.DATA_OUT    = data_r;
  assign bus.NEXT_WRITE  = next_wr_r;
  assign bus.NEXT_READ   = next_rd_r;
  assign bus.DROP        = drop_r;
  assign bus.TIMEOUT_ERR = timeout_r;

endmodule

// File: tb/tb_memory_scheduler.sv
// Bench for memory_scheduler: the bench plays packet sources, address counters
// and the SRAM. A queue of expected operations (arrival order, one pending per
// source) predicts every command, word, address, completion pulse and drop.
module tb_memory_scheduler;
  localparam int NCH   = 2;
  localparam int PW    = 80;
  localparam int WW    = 16;
  localparam int AW    = 18;
  localparam int WORDS = PW / WW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  memory_scheduler_if #(.NUM_CH(NCH), .PKT_WIDTH(PW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW)) bus ();

  memory_scheduler #(.NUM_CH(NCH), .PKT_WIDTH(PW), .WORD_WIDTH(WW), .ADDR_WIDTH(AW),
                     .QUEUE_DEPTH(4), .BUSY_TIMEOUT(15))
    dut (.CLK_48MHZ(clk), .RESET(rst), .bus(bus));

  typedef struct {
    logic          rd;
    int            ch;
    logic [PW-1:0] data;
  } op_t;

  op_t ops[$];
  logic [NCH-1:0] pend;
  logic    rd_pend, rd_level_q, exp_drop, sram_status, catchup_mode, ignore_busy;
  logic [1:0] prev_cmd;
  logic [AW-1:0] wr_cnt, rd_cnt;
  int words_done, busy_left, busy_len;
  int n_checks = 0, n_fail = 0;
  int cmd_seen = 0, nw_count = 0, nr_count = 0, drop_total = 0;

  task automatic check_value(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    n_checks++;
    if (observed !== expected) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic model_reset();
    ops.delete();
    pend = '0; rd_pend = 1'b0; rd_level_q = 1'b0; exp_drop = 1'b0;
    sram_status = 1'b0; prev_cmd = 2'b00; words_done = 0; busy_left = 0;
  endtask

  // Observe outputs produced by the last clock edge and play the SRAM.
  task automatic monitor();
    logic [WW-1:0] word;
    check_value("drop", bus.DROP, exp_drop);
    if (bus.CMD_OUT != 2'b00 && prev_cmd == 2'b00) begin
      cmd_seen++;
      if (ops.size() == 0) begin
        check_value("spurious_cmd", bus.CMD_OUT, 2'b00);
      end else if (ops[0].rd) begin
        check_value("rd_cmd", bus.CMD_OUT, 2'b01);
        check_value("rd_addr", bus.ADDRESS_OUT, rd_cnt);
        check_value("rd_cs", bus.CHIP_SELECT, 1'b0);
      end else begin
        word = ops[0].data[words_done*WW +: WW];
        check_value("wr_cmd", bus.CMD_OUT, 2'b10);
        check_value("wr_data", bus.DATA_OUT, word);
        check_value("wr_addr", bus.ADDRESS_OUT, wr_cnt);
        check_value("wr_cs", bus.CHIP_SELECT, 1'b1);
      end
      if (!ignore_busy) begin
        sram_status = 1'b1;
        busy_left = (busy_len != 0) ? busy_len : int'($urandom_range(1, 3));
      end
    end else if (sram_status) begin
      busy_left--;
      if (busy_left == 0) sram_status = 1'b0;
    end
    prev_cmd = bus.CMD_OUT;
    if (bus.NEXT_WRITE) begin
      nw_count++;
      if (ops.size() == 0 || ops[0].rd) begin
        check_value("next_write_unexpected", bus.NEXT_WRITE, 1'b0);
      end else begin
        words_done++;
        wr_cnt++;
        if (words_done == WORDS) begin
          pend[ops[0].ch] = 1'b0;
          void'(ops.pop_front());
          words_done = 0;
        end
      end
    end
    if (bus.NEXT_READ) begin
      nr_count++;
      if (ops.size() == 0 || !ops[0].rd) begin
        check_value("next_read_unexpected", bus.NEXT_READ, 1'b0);
      end else begin
        rd_cnt++;
        rd_pend = 1'b0;
        void'(ops.pop_front());
      end
    end
  endtask

  // Apply requests for the coming edge and predict acceptance or drop.
  task automatic drive(input logic [NCH-1:0] valid, input logic [NCH*PW-1:0] data, input logic rd);
    op_t o;
    exp_drop = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (valid[c]) begin
        if (!pend[c]) begin
          pend[c] = 1'b1;
          o.rd = 1'b0; o.ch = c; o.data = data[c*PW +: PW];
          ops.push_back(o);
        end else begin
          exp_drop = 1'b1;
        end
      end
    end
    if (rd && !rd_level_q && !catchup_mode) begin
      if (!rd_pend) begin
        rd_pend = 1'b1;
        o.rd = 1'b1; o.ch = 0; o.data = '0;
        ops.push_back(o);
      end else begin
        exp_drop = 1'b1;
      end
    end
    rd_level_q = rd;
    if (exp_drop) drop_total++;
    bus.CH_VALID    = valid;
    bus.CH_DATA     = data;
    bus.READ_CMD    = rd;
    bus.SRAM_STATUS = sram_status;
    if (catchup_mode) begin
      bus.WRITE_ADDRESS = 18'h3FFFF; bus.WRITE_CHIP_SELECT = 1'b1;
      bus.READ_ADDRESS  = 18'h3FFFF; bus.READ_CHIP_SELECT  = 1'b1;
    end else begin
      bus.WRITE_ADDRESS = wr_cnt; bus.WRITE_CHIP_SELECT = 1'b1;
      bus.READ_ADDRESS  = rd_cnt; bus.READ_CHIP_SELECT  = 1'b0;
    end
  endtask

  task automatic tick(input logic [NCH-1:0] valid, input logic [NCH*PW-1:0] data, input logic rd);
    @(negedge clk);
    monitor();
    drive(valid, data, rd);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while ((ops.size() != 0 || bus.CMD_OUT != 2'b00 || sram_status) && n < 3000) begin
      tick('0, '0, 1'b0);
      n++;
    end
    check_value(tag, ops.size(), 0);
    repeat (3) tick('0, '0, 1'b0);
  endtask

  function automatic logic [NCH*PW-1:0] rand_data();
    logic [NCH*PW-1:0] d;
    for (int k = 0; k < NCH*PW/32; k++) d[k*32 +: 32] = $urandom;
    return d;
  endfunction

  int c0, w0, r0, n, t;
  logic found;
  logic [NCH-1:0] v;
  logic r;

  initial begin
    wr_cnt = 18'h00100; rd_cnt = 18'h20000;
    catchup_mode = 1'b0; ignore_busy = 1'b0; busy_len = 0;
    model_reset();
    drive('0, '0, 1'b0);
    repeat (3) @(negedge clk);

    // Reset values while RESET is held
    check_value("rst_cmd", bus.CMD_OUT, 2'b00);
    check_value("rst_addr", bus.ADDRESS_OUT, 18'h0);
    check_value("rst_cs", bus.CHIP_SELECT, 1'b0);
    check_value("rst_data", bus.DATA_OUT, 16'h0);
    check_value("rst_nw", bus.NEXT_WRITE, 1'b0);
    check_value("rst_nr", bus.NEXT_READ, 1'b0);
    check_value("rst_drop", bus.DROP, 1'b0);
    check_value("rst_timeout", bus.TIMEOUT_ERR, 1'b0);
    rst = 1'b0;

    // Asynchronous reset in the middle of a packet
    c0 = cmd_seen;
    tick(2'b01, rand_data(), 1'b0);
    n = 0;
    while (cmd_seen < c0 + 3 && n < 200) begin tick('0, '0, 1'b0); n++; end
    check_value("mid_reset_reached", cmd_seen - c0, 3);
    #2 rst = 1'b1;
    #1;
    check_value("async_cmd", bus.CMD_OUT, 2'b00);
    check_value("async_addr", bus.ADDRESS_OUT, 18'h0);
    check_value("async_data", bus.DATA_OUT, 16'h0);
    check_value("async_cs", bus.CHIP_SELECT, 1'b0);
    model_reset();
    drive('0, '0, 1'b0);
    repeat (2) tick('0, '0, 1'b0);
    rst = 1'b0;
    c0 = cmd_seen;
    repeat (15) tick('0, '0, 1'b0);
    check_value("queue_empty_after_reset", cmd_seen - c0, 0);

    // Single write, fixed 2-cycle busy
    busy_len = 2;
    w0 = nw_count;
    tick(2'b01, {80'h0, 80'h1111_2222_3333_4444_5555}, 1'b0);
    drain("single_drain");
    check_value("single_nw", nw_count - w0, 5);
    busy_len = 0;

    // Both channels plus a read in the same cycle
    w0 = nw_count; r0 = nr_count;
    tick(2'b11, rand_data(), 1'b1);
    tick('0, '0, 1'b0);
    drain("simul_drain");
    check_value("simul_nw", nw_count - w0, 10);
    check_value("simul_nr", nr_count - r0, 1);

    // Read catches up with write: no command, no NEXT_READ
    catchup_mode = 1'b1;
    c0 = cmd_seen; r0 = nr_count;
    tick('0, '0, 1'b0);
    tick('0, '0, 1'b1);
    repeat (20) tick('0, '0, 1'b0);
    check_value("catchup_cmd", cmd_seen - c0, 0);
    check_value("catchup_nr", nr_count - r0, 0);
    catchup_mode = 1'b0;
    tick('0, '0, 1'b1);
    tick('0, '0, 1'b0);
    drain("catchup_drain");
    check_value("catchup_rd_pend_cleared", nr_count - r0, 1);

    // Second CH_VALID[0] three cycles after the first is dropped
    w0 = nw_count; c0 = drop_total;
    tick(2'b01, rand_data(), 1'b0);
    repeat (2) tick('0, '0, 1'b0);
    tick(2'b01, rand_data(), 1'b0);
    drain("drop_drain");
    check_value("drop_nw", nw_count - w0, 5);
    check_value("drop_predicted", drop_total - c0, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) v[c] = ($urandom_range(0, 7) == 0);
      r = rd_level_q ? 1'b0 : ($urandom_range(0, 9) == 0);
      tick(v, rand_data(), r);
    end
    tick('0, '0, 1'b0);
    drain("random_drain");
    check_value("no_timeout_yet", bus.TIMEOUT_ERR, 1'b0);

    // SRAM never goes busy: timeout after 15 cycles, same word reissued
    ignore_busy = 1'b1;
    c0 = cmd_seen; w0 = nw_count;
    tick(2'b10, rand_data(), 1'b0);
    n = 0;
    while (cmd_seen == c0 && n < 20) begin tick('0, '0, 1'b0); n++; end
    check_value("to_first_cmd", cmd_seen - c0, 1);
    t = 0; found = 1'b0;
    while (!found && t < 40) begin
      tick('0, '0, 1'b0);
      t++;
      if (bus.TIMEOUT_ERR) found = 1'b1;
    end
    check_value("to_cycles", t, 15);
    ignore_busy = 1'b0;
    tick('0, '0, 1'b0);
    check_value("to_retry", cmd_seen - c0, 2);
    drain("to_drain");
    check_value("to_nw", nw_count - w0, 5);
    check_value("to_sticky", bus.TIMEOUT_ERR, 1'b1);

`ifdef MEMSCHED_DROP_COUNT_EN
    check_value("drop_count", bus.DROP_COUNT, (drop_total > 255) ? 255 : drop_total);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global guard so the run always ends.
  initial begin
    #2000000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1);
  end
endmodule
